// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a valid/ready handshake, a 2-entry skid buffer,
// a registered in_ready, synchronous flush, bubble-safe control zeroing and a stall counter.
module pipe_stage_skid #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CTRL_W-1:0] CTRL_ZERO = {CTRL_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, main_ctrl_s;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              accept_s;
  logic              fire_s;

  assign accept_s = in_valid & in_ready_q & ~flush;
  assign fire_s   = out_valid_q & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_s) state_d = ONE;
          else          state_d = EMPTY;
        end
        ONE: begin
          if (accept_s & ~fire_s)      state_d = TWO;
          else if (~accept_s & fire_s) state_d = EMPTY;
          else                         state_d = ONE;
        end
        TWO: begin
          if (fire_s) state_d = ONE;
          else        state_d = TWO;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Datapath moves are frozen during flush so out_data keeps the last presented payload.
  always_comb begin
    main_data_d = main_data_q;
    main_ctrl_s = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (!flush) begin
      case (state_q)
        EMPTY: begin
          if (accept_s) begin
            main_data_d = in_data;
            main_ctrl_s = in_ctrl;
          end else begin
            main_data_d = main_data_q;
          end
        end
        ONE: begin
          if (accept_s & fire_s) begin
            main_data_d = in_data;
            main_ctrl_s = in_ctrl;
          end else if (accept_s) begin
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else begin
            main_data_d = main_data_q;
          end
        end
        TWO: begin
          if (fire_s) begin
            main_data_d = skid_data_q;
            main_ctrl_s = skid_ctrl_q;
          end else begin
            main_data_d = main_data_q;
          end
        end
        default: main_data_d = main_data_q;
      endcase
    end else begin
      main_data_d = main_data_q;
    end
    main_ctrl_d = (state_d != EMPTY) ? main_ctrl_s : CTRL_ZERO;
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
    if (out_valid_q & ~out_ready & (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_data_q <= DATA_ZERO;
      main_ctrl_q <= CTRL_ZERO;
      skid_data_q <= DATA_ZERO;
      skid_ctrl_q <= CTRL_ZERO;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule
